// File: rtl/random_range_gen.sv
// random_range_gen: LFSR random source with seed load and stuck-at-zero
// recovery, plus a request/valid draw engine that returns a uniform index
// in [0,RANGE) by rejection sampling. An optional rule forbids returning
// the same index twice in a row. A fallback value bounds the latency.
module random_range_gen #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hD008,
    parameter int              OUT_W     = 4,
    parameter int              RANGE     = 9,
    parameter int              NO_REPEAT = 1,
    parameter int              MAX_TRIES = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic [WIDTH-1:0] state
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    // RANGE may equal 2**OUT_W, so comparisons use one extra bit.
    localparam logic [OUT_W:0]   RANGE_C  = (OUT_W+1)'(RANGE);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {
        S_IDLE,
        S_DRAW
    } fsm_t;

    fsm_t             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [TRY_W-1:0] tries_q;
    logic [OUT_W-1:0] value_q;
    logic             have_last_q;
    logic             busy_q;
    logic             valid_q;

    logic [OUT_W-1:0] cand;
    logic             in_range;
    logic             is_repeat;
    logic             accept;
    logic [OUT_W:0]   last_inc;
    logic [OUT_W-1:0] fallback;

    // Next LFSR value for one step; an all-zero state is forced back to
    // all ones because the shift register would otherwise lock up.
    always_comb begin
        state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        if (state_q == '0) begin
            state_d = '1;
        end
    end

    // Candidate evaluation; value_q doubles as the last accepted index
    // since both only change on accept or fallback.
    always_comb begin
        cand      = state_q[OUT_W-1:0];
        in_range  = ({1'b0, cand} < RANGE_C);
        is_repeat = (NO_REPEAT != 0) && (RANGE > 1) && have_last_q &&
                    (cand == value_q);
        accept    = in_range && !is_repeat;
        last_inc  = {1'b0, value_q} + 1'b1;
        fallback  = '0;
        if (have_last_q && (last_inc != RANGE_C)) begin
            fallback = last_inc[OUT_W-1:0];
        end
    end

    // Main FSM: reset beats load, load beats idle/draw activity.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= '1;
            fsm_q       <= S_IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            value_q     <= '0;
            have_last_q <= 1'b0;
            tries_q     <= '0;
        end else if (load) begin
            state_q <= (seed == '0) ? '1 : seed;
            fsm_q   <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            tries_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (enable || (state_q == '0)) begin
                        state_q <= state_d;
                    end
                    if (req) begin
                        fsm_q   <= S_DRAW;
                        busy_q  <= 1'b1;
                        tries_q <= '0;
                    end
                end
                S_DRAW: begin
                    state_q <= state_d;
                    if (accept || (tries_q == TRY_LAST)) begin
                        value_q     <= accept ? cand : fallback;
                        have_last_q <= 1'b1;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        fsm_q       <= S_IDLE;
                        tries_q     <= '0;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                    end
                end
                default: begin
                    fsm_q  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign value = value_q;
    assign state = state_q;

endmodule

// File: tb/tb_random_range_gen.sv
// Testbench for random_range_gen: LFSR stepping vectors, directed draws,
// draw abort by load, fallback with MAX_TRIES=1, and an 8-bit period check.
module tb_random_range_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default instance
    logic        d_load, d_en, d_req, d_busy, d_valid;
    logic [15:0] d_seed, d_state;
    logic [3:0]  d_value;

    // MAX_TRIES = 1 instance
    logic        m_load, m_en, m_req, m_busy, m_valid;
    logic [15:0] m_seed, m_state;
    logic [3:0]  m_value;

    // WIDTH = 8 instance
    logic        w_load, w_en, w_req, w_busy, w_valid;
    logic [7:0]  w_seed, w_state;
    logic [3:0]  w_value;

    random_range_gen dut_d (
        .clock(clk), .reset(rst), .load(d_load), .seed(d_seed), .enable(d_en),
        .req(d_req), .busy(d_busy), .valid(d_valid), .value(d_value), .state(d_state)
    );

    random_range_gen #(.MAX_TRIES(1)) dut_m (
        .clock(clk), .reset(rst), .load(m_load), .seed(m_seed), .enable(m_en),
        .req(m_req), .busy(m_busy), .valid(m_valid), .value(m_value), .state(m_state)
    );

    random_range_gen #(.WIDTH(8), .TAPS(8'hB8)) dut_w (
        .clock(clk), .reset(rst), .load(w_load), .seed(w_seed), .enable(w_en),
        .req(w_req), .busy(w_busy), .valid(w_valid), .value(w_value), .state(w_state)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        load;
        logic [15:0] seed;
        logic        en;
        logic [15:0] exp_state;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One draw on the default instance; lat counts edges from the req edge
    // (inclusive) up to the edge after which valid is seen.
    task automatic d_draw(output int lat, output bit got);
        d_req = 1'b1;
        tick();
        d_req = 1'b0;
        chk("draw_busy", {31'b0, d_busy}, 32'd1);
        chk("draw_no_valid_first", {31'b0, d_valid}, 32'd0);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            if (d_valid) got = 1'b1;
        end
        chk("draw_done", {31'b0, got}, 32'd1);
        if (got) chk("draw_busy_clear", {31'b0, d_busy}, 32'd0);
    endtask

    // Hard bound on simulated time
    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit got;
        logic [3:0] prev;
        bit seen[16];
        int first_ret;
        bit zero_seen;

        rst = 1'b1;
        d_load = 0; d_en = 0; d_req = 0; d_seed = '0;
        m_load = 0; m_en = 0; m_req = 0; m_seed = '0;
        w_load = 0; w_en = 0; w_req = 0; w_seed = '0;

        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'hFFFF};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'hFFFF};
        vecs[2]  = '{1'b1, 16'h0000, 1'b0, 16'hFFFF};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFE};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFC};
        vecs[5]  = '{1'b1, 16'h8000, 1'b0, 16'h8000};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0001};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 16'h0002};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0002};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 16'h0004};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h0008};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 16'h0011};
        vecs[12] = '{1'b1, 16'h1234, 1'b1, 16'h1234};
        vecs[13] = '{1'b1, 16'h0111, 1'b0, 16'h0111};

        tick();
        tick();
        chk("reset_state", {16'b0, d_state}, 32'hFFFF);
        chk("reset_busy", {31'b0, d_busy}, 32'd0);
        chk("reset_valid", {31'b0, d_valid}, 32'd0);
        chk("reset_value", {28'b0, d_value}, 32'd0);
        chk("reset_state_w8", {24'b0, w_state}, 32'hFF);
        $display("reset: state=%h busy=%b valid=%b value=%0d", d_state, d_busy, d_valid, d_value);
        rst = 1'b0;

        // LFSR stepping / load vectors
        for (int i = 0; i < 14; i++) begin
            d_load = vecs[i].load;
            d_seed = vecs[i].seed;
            d_en   = vecs[i].en;
            tick();
            chk($sformatf("vec%0d_state", i), {16'b0, d_state}, {16'b0, vecs[i].exp_state});
            chk($sformatf("vec%0d_valid", i), {31'b0, d_valid}, 32'd0);
            $display("vec %0d: load=%b seed=%h en=%b state=%h", i, vecs[i].load, vecs[i].seed, vecs[i].en, d_state);
        end
        d_load = 0; d_en = 0;

        // Directed draw: candidate 1 accepted at once
        d_draw(lat, got);
        chk("dir1_value", {28'b0, d_value}, 32'd1);
        chk("dir1_lat", lat, 32'd2);
        $display("draw dir1: value=%0d lat=%0d", d_value, lat);

        // Same seed: 1 is a repeat, next candidate 2 accepted
        d_load = 1; d_seed = 16'h0111; tick(); d_load = 0;
        d_draw(lat, got);
        chk("dir2_value", {28'b0, d_value}, 32'd2);
        chk("dir2_lat", lat, 32'd3);
        $display("draw dir2: value=%0d lat=%0d", d_value, lat);

        // Seed 000F: fourteen rejects then candidate 5
        d_load = 1; d_seed = 16'h000F; tick(); d_load = 0;
        d_draw(lat, got);
        chk("dir3_value", {28'b0, d_value}, 32'd5);
        chk("dir3_lat", lat, 32'd16);
        $display("draw dir3: value=%0d lat=%0d", d_value, lat);

        // Abort a draw with load on its first DRAW cycle
        d_req = 1; tick(); d_req = 0;
        chk("abort_busy_before", {31'b0, d_busy}, 32'd1);
        d_load = 1; d_seed = 16'h0111; tick(); d_load = 0;
        chk("abort_busy", {31'b0, d_busy}, 32'd0);
        chk("abort_valid", {31'b0, d_valid}, 32'd0);
        chk("abort_value", {28'b0, d_value}, 32'd5);
        chk("abort_state", {16'b0, d_state}, 32'h0111);
        tick();
        chk("abort_valid_after", {31'b0, d_valid}, 32'd0);
        chk("abort_busy_after", {31'b0, d_busy}, 32'd0);
        $display("abort: busy=%b valid=%b value=%0d", d_busy, d_valid, d_value);
        d_draw(lat, got);
        chk("post_abort_value", {28'b0, d_value}, 32'd1);
        chk("post_abort_lat", lat, 32'd2);
        $display("draw post_abort: value=%0d lat=%0d", d_value, lat);

        // Many draws with mixed idle enable
        prev = d_value;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            d_en = 1'(($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) tick();
            d_draw(lat, got);
            chk("rnd_in_range", {31'b0, d_value < 4'd9}, 32'd1);
            chk("rnd_no_repeat", {31'b0, d_value != prev}, 32'd1);
            chk("rnd_lat", {31'b0, (lat >= 2) && (lat <= 33)}, 32'd1);
            seen[d_value] = 1'b1;
            prev = d_value;
            $display("draw %0d: value=%0d lat=%0d", n, d_value, lat);
        end
        d_en = 0;
        for (int i = 0; i < 9; i++) chk($sformatf("seen_%0d", i), {31'b0, seen[i]}, 32'd1);

        // MAX_TRIES=1: fallback 0, then last+1
        m_load = 1; m_seed = 16'h000F; tick(); m_load = 0;
        m_req = 1; tick(); m_req = 0;
        chk("m1_busy", {31'b0, m_busy}, 32'd1);
        chk("m1_no_valid", {31'b0, m_valid}, 32'd0);
        tick();
        chk("m1_valid", {31'b0, m_valid}, 32'd1);
        chk("m1_value", {28'b0, m_value}, 32'd0);
        $display("fallback 1: valid=%b value=%0d", m_valid, m_value);
        m_load = 1; m_seed = 16'h000F; tick(); m_load = 0;
        m_req = 1; tick(); m_req = 0;
        tick();
        chk("m2_valid", {31'b0, m_valid}, 32'd1);
        chk("m2_value", {28'b0, m_value}, 32'd1);
        $display("fallback 2: valid=%b value=%0d", m_valid, m_value);

        // 8-bit LFSR period from all ones
        rst = 1; tick(); rst = 0;
        chk("w8_start", {24'b0, w_state}, 32'hFF);
        first_ret = 0;
        zero_seen = 1'b0;
        w_en = 1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (w_state == 8'h00) zero_seen = 1'b1;
            if (w_state == 8'hFF && first_ret == 0) first_ret = i;
        end
        w_en = 0;
        chk("w8_period", first_ret, 32'd255);
        chk("w8_no_zero", {31'b0, zero_seen}, 32'd0);
        $display("w8: period=%0d zero_seen=%b", first_ret, zero_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
